// File: rtl/uart_modport.sv
// Slave-side UART endpoint: deserializes frames on tx into a host holding register and
// serializes host bytes onto rx, with cts_n/rts_n flow control and receive error flags.
module uart_modport #(
    parameter int unsigned CLKS_PER_BIT = 1085,
    parameter int unsigned DATA_BITS    = 8,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx,
    input  logic                 rts_n,
    output logic                 rx,
    output logic                 cts_n,
    output logic                 tx_busy,
    output logic                 rx_ready,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 overrun_error,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack
);

    localparam int unsigned    CntW     = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2);
    localparam logic [2:0]      IdxLast = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    // ------------------------------------------------------------------ receiver
    logic                 tx_s1, tx_s2;
    state_e               rx_state_q, rx_state_d;
    logic [CntW-1:0]      rx_cnt_q, rx_cnt_d;
    logic [2:0]           rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic                 rx_par_q, rx_par_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 fe_q, fe_d, pe_q, pe_d, ovr_q, ovr_d;
    logic                 cts_n_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_s1      <= 1'b1;
            tx_s2      <= 1'b1;
            rx_state_q <= StIdle;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_sh_q    <= '0;
            rx_par_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            fe_q       <= 1'b0;
            pe_q       <= 1'b0;
            ovr_q      <= 1'b0;
            cts_n_q    <= 1'b1;
        end else begin
            tx_s1      <= tx;
            tx_s2      <= tx_s1;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_sh_q    <= rx_sh_d;
            rx_par_q   <= rx_par_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            fe_q       <= fe_d;
            pe_q       <= pe_d;
            ovr_q      <= ovr_d;
            cts_n_q    <= rx_valid_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_sh_d    = rx_sh_q;
        rx_par_d   = rx_par_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        fe_d       = fe_q;
        pe_d       = pe_q;
        ovr_d      = ovr_q;
        if (rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
            ovr_d      = 1'b0;
        end
        unique case (rx_state_q)
            StIdle: begin
                if (!tx_s2) begin
                    rx_state_d = StStart;
                    rx_cnt_d   = CntHalf;
                end
            end
            StStart: begin
                if (rx_cnt_q == '0) begin
                    if (tx_s2) begin
                        rx_state_d = StIdle;
                    end else begin
                        rx_state_d = StData;
                        rx_cnt_d   = CntLast;
                        rx_idx_d   = '0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            StData: begin
                if (rx_cnt_q == '0) begin
                    rx_sh_d  = {tx_s2, rx_sh_q[DATA_BITS-1:1]};
                    rx_cnt_d = CntLast;
                    if (rx_idx_q == IdxLast) begin
                        rx_state_d = PARITY_EN ? StParity : StStop;
                    end else begin
                        rx_idx_d = rx_idx_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            StParity: begin
                if (rx_cnt_q == '0) begin
                    rx_par_d   = tx_s2;
                    rx_state_d = StStop;
                    rx_cnt_d   = CntLast;
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            StStop: begin
                if (rx_cnt_q == '0) begin
                    // Leave at the stop-bit centre so a back-to-back start edge is not missed.
                    rx_state_d = StIdle;
                    if (!rx_valid_q || rx_ack) begin
                        rx_data_d  = rx_sh_q;
                        rx_valid_d = 1'b1;
                        fe_d       = !tx_s2;
                        pe_d       = PARITY_EN && ((^rx_sh_q ^ rx_par_q) != PARITY_ODD);
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            default: rx_state_d = StIdle;
        endcase
    end

    assign tx_busy       = (rx_state_q != StIdle) || !tx;
    assign cts_n         = cts_n_q;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign frame_error   = fe_q;
    assign parity_error  = pe_q;
    assign overrun_error = ovr_q;

    // --------------------------------------------------------------- transmitter
    state_e               tx_state_q, tx_state_d;
    logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_idx_q, tx_idx_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic                 tx_par_q, tx_par_d;
    logic                 rx_q, rx_d;
    logic                 rx_ready_q, tx_ready_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= StIdle;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_sh_q    <= '0;
            tx_par_q   <= 1'b0;
            rx_q       <= 1'b1;
            rx_ready_q <= 1'b0;
            tx_ready_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_sh_q    <= tx_sh_d;
            tx_par_q   <= tx_par_d;
            rx_q       <= rx_d;
            rx_ready_q <= (tx_state_d != StIdle);
            tx_ready_q <= (tx_state_d == StIdle);
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        if (tx_state_q == StIdle) begin
            if (tx_valid && tx_ready_q && !rts_n) begin
                tx_state_d = StStart;
                tx_sh_d    = tx_data;
                tx_cnt_d   = '0;
                tx_par_d   = ^tx_data ^ PARITY_ODD;
            end
        end else if (tx_cnt_q == CntLast) begin
            tx_cnt_d = '0;
            unique case (tx_state_q)
                StStart: begin
                    tx_state_d = StData;
                    tx_idx_d   = '0;
                end
                StData: begin
                    tx_sh_d = tx_sh_q >> 1;
                    if (tx_idx_q == IdxLast) begin
                        tx_state_d = PARITY_EN ? StParity : StStop;
                    end else begin
                        tx_idx_d = tx_idx_q + 1'b1;
                    end
                end
                StParity: tx_state_d = StStop;
                default:  tx_state_d = StIdle;
            endcase
        end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
        end
    end

    // The line level is registered from the next state so it changes with the state.
    always_comb begin
        rx_d = 1'b1;
        unique case (tx_state_d)
            StStart:  rx_d = 1'b0;
            StData:   rx_d = tx_sh_d[0];
            StParity: rx_d = tx_par_d;
            default:  rx_d = 1'b1;
        endcase
    end

    assign rx       = rx_q;
    assign rx_ready = rx_ready_q;
    assign tx_ready = tx_ready_q;

endmodule

// File: tb/tb_uart_modport.sv
// Scoreboard bench for uart_modport: an 8N1 instance for both directions and an
// even-parity instance for receive parity checking, CLKS_PER_BIT=16.
module tb_uart_modport;

    localparam int unsigned Cpb = 16;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t       exp0_q[$];
    exp_t       exp1_q[$];
    logic [7:0] txq[$];

    // 8N1 instance
    logic       tx0 = 1'b1, rts_n0 = 1'b0, tx_valid0 = 1'b0, rx_ack0 = 1'b0;
    logic [7:0] tx_data0 = 8'h00;
    logic       rx0, cts_n0, tx_busy0, rx_ready0, fe0, pe0, ovr0, tx_ready0, rx_valid0;
    logic [7:0] rx_data0;

    // 8E1 instance
    logic       tx1 = 1'b1, rx_ack1 = 1'b0;
    logic       rts_n1 = 1'b1, tx_valid1 = 1'b0;
    logic [7:0] tx_data1 = 8'h00;
    logic       rx1, cts_n1, tx_busy1, rx_ready1, fe1, pe1, ovr1, tx_ready1, rx_valid1;
    logic [7:0] rx_data1;

    uart_modport #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u0 (
        .clk(clk), .rst(rst), .tx(tx0), .rts_n(rts_n0), .rx(rx0), .cts_n(cts_n0),
        .tx_busy(tx_busy0), .rx_ready(rx_ready0), .frame_error(fe0), .parity_error(pe0),
        .overrun_error(ovr0), .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ack(rx_ack0)
    );

    uart_modport #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u1 (
        .clk(clk), .rst(rst), .tx(tx1), .rts_n(rts_n1), .rx(rx1), .cts_n(cts_n1),
        .tx_busy(tx_busy1), .rx_ready(rx_ready1), .frame_error(fe1), .parity_error(pe1),
        .overrun_error(ovr1), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ack(rx_ack1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) tx1 = v;
        else tx0 = v;
        repeat (Cpb) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit par,
                              input logic pbit, input logic stop);
        @(negedge clk);
        drive(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive(sel, d[i]);
        if (par) drive(sel, pbit);
        drive(sel, stop);
        if (sel) tx1 = 1'b1;
        else tx0 = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic ack(input bit sel);
        @(negedge clk);
        if (sel) rx_ack1 = 1'b1;
        else rx_ack0 = 1'b1;
        @(negedge clk);
        rx_ack0 = 1'b0;
        rx_ack1 = 1'b0;
    endtask

    // Receive scoreboard monitors: compare on each new rx_valid.
    logic prev_v0 = 1'b0, prev_v1 = 1'b0;
    always @(negedge clk) begin
        if (rx_valid0 === 1'b1 && !prev_v0) begin
            if (exp0_q.size() == 0) begin
                check("u0_unexpected_byte", {24'h0, rx_data0}, 32'hffff_ffff);
            end else begin
                exp_t e;
                e = exp0_q.pop_front();
                check("u0_rx_data", {24'h0, rx_data0}, {24'h0, e.d});
                check("u0_frame_error", {31'h0, fe0}, {31'h0, e.fe});
                check("u0_parity_error", {31'h0, pe0}, {31'h0, e.pe});
                check("u0_cts_n", {31'h0, cts_n0}, 32'h1);
            end
        end
        prev_v0 <= rx_valid0;
    end

    always @(negedge clk) begin
        if (rx_valid1 === 1'b1 && !prev_v1) begin
            if (exp1_q.size() == 0) begin
                check("u1_unexpected_byte", {24'h0, rx_data1}, 32'hffff_ffff);
            end else begin
                exp_t e;
                e = exp1_q.pop_front();
                check("u1_rx_data", {24'h0, rx_data1}, {24'h0, e.d});
                check("u1_frame_error", {31'h0, fe1}, {31'h0, e.fe});
                check("u1_parity_error", {31'h0, pe1}, {31'h0, e.pe});
            end
        end
        prev_v1 <= rx_valid1;
    end

    // Serial line monitor for u0's transmitter: samples each bit at its centre.
    initial begin
        logic [7:0] got;
        logic       st, sp;
        forever begin
            @(negedge clk);
            if (rx0 === 1'b0 && rx_ready0 === 1'b1) begin
                repeat (7) @(negedge clk);
                st = rx0;
                for (int i = 0; i < 8; i++) begin
                    repeat (Cpb) @(negedge clk);
                    got[i] = rx0;
                end
                repeat (Cpb) @(negedge clk);
                sp = rx0;
                if (txq.size() != 0) begin
                    logic [7:0] e;
                    e = txq.pop_front();
                    check("tx_start_bit", {31'h0, st}, 32'h0);
                    check("tx_line_data", {24'h0, got}, {24'h0, e});
                    check("tx_stop_bit", {31'h0, sp}, 32'h1);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rx", {31'h0, rx0}, 32'h1);
        check("rst_cts_n", {31'h0, cts_n0}, 32'h1);
        check("rst_tx_busy", {31'h0, tx_busy0}, 32'h0);
        check("rst_rx_ready", {31'h0, rx_ready0}, 32'h0);
        check("rst_errors", {29'h0, fe0, pe0, ovr0}, 32'h0);
        check("rst_tx_ready", {31'h0, tx_ready0}, 32'h0);
        check("rst_rx_valid", {31'h0, rx_valid0}, 32'h0);
        check("rst_rx_data", {24'h0, rx_data0}, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_cts_n", {31'h0, cts_n0}, 32'h0);
        check("post_rst_tx_ready", {31'h0, tx_ready0}, 32'h1);

        // Short low glitch must be rejected as a false start.
        @(negedge clk);
        tx0 = 1'b0;
        #1 check("glitch_tx_busy", {31'h0, tx_busy0}, 32'h1);
        repeat (4) @(negedge clk);
        tx0 = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_rx_valid", {31'h0, rx_valid0}, 32'h0);
        check("glitch_errors", {29'h0, fe0, pe0, ovr0}, 32'h0);
        check("glitch_tx_busy_idle", {31'h0, tx_busy0}, 32'h0);

        // Clean frame 0xA3.
        exp0_q.push_back('{d: 8'hA3, fe: 1'b0, pe: 1'b0});
        send_frame(1'b0, 8'hA3, 1'b0, 1'b0, 1'b1);
        check("a3_cts_n_held", {31'h0, cts_n0}, 32'h1);
        ack(1'b0);
        check("a3_ack_rx_valid", {31'h0, rx_valid0}, 32'h0);
        check("a3_ack_cts_n", {31'h0, cts_n0}, 32'h0);

        // Framing error: stop bit low, data still delivered.
        exp0_q.push_back('{d: 8'h0F, fe: 1'b1, pe: 1'b0});
        send_frame(1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);
        repeat (30) @(negedge clk);
        ack(1'b0);

        // Overrun: second frame arrives with the first unread.
        exp0_q.push_back('{d: 8'h11, fe: 1'b0, pe: 1'b0});
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        check("ovr_rx_data", {24'h0, rx_data0}, 32'h11);
        check("ovr_flag", {31'h0, ovr0}, 32'h1);
        check("ovr_fe_kept", {31'h0, fe0}, 32'h0);
        ack(1'b0);
        check("ovr_ack_rx_valid", {31'h0, rx_valid0}, 32'h0);
        check("ovr_ack_flag", {31'h0, ovr0}, 32'h0);

        // Even parity on 0x07: correct parity bit is 1.
        exp1_q.push_back('{d: 8'h07, fe: 1'b0, pe: 1'b1});
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        ack(1'b1);
        exp1_q.push_back('{d: 8'h07, fe: 1'b0, pe: 1'b0});
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        ack(1'b1);

        // Transmit: held off by rts_n, then 0x55 once rts_n asserts.
        @(negedge clk);
        rts_n0 = 1'b1;
        tx_data0 = 8'h55;
        tx_valid0 = 1'b1;
        repeat (20) @(negedge clk);
        check("rts_hold_rx", {31'h0, rx0}, 32'h1);
        check("rts_hold_rx_ready", {31'h0, rx_ready0}, 32'h0);
        check("rts_hold_tx_ready", {31'h0, tx_ready0}, 32'h1);
        txq.push_back(8'h55);
        rts_n0 = 1'b0;
        @(posedge clk);
        #1;
        tx_valid0 = 1'b0;
        check("tx_first_rx", {31'h0, rx0}, 32'h0);
        check("tx_first_rx_ready", {31'h0, rx_ready0}, 32'h1);
        check("tx_first_tx_ready", {31'h0, tx_ready0}, 32'h0);
        n = 1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (rx_ready0 !== 1'b1) break;
            n++;
        end
        check("tx_rx_ready_len", n, 10 * Cpb);
        check("tx_done_tx_ready", {31'h0, tx_ready0}, 32'h1);
        check("tx_done_rx", {31'h0, rx0}, 32'h1);
        repeat (4) @(negedge clk);
        check("tx_queue_drained", txq.size(), 0);

        // Reset mid-transmit.
        @(negedge clk);
        tx_data0 = 8'h00;
        tx_valid0 = 1'b1;
        @(negedge clk);
        tx_valid0 = 1'b0;
        repeat (40) @(negedge clk);
        check("mid_tx_rx_ready", {31'h0, rx_ready0}, 32'h1);
        rst = 1'b0;
        #1;
        check("mid_rst_rx", {31'h0, rx0}, 32'h1);
        check("mid_rst_rx_ready", {31'h0, rx_ready0}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (200) @(negedge clk);
        check("after_rst_rx", {31'h0, rx0}, 32'h1);
        check("after_rst_rx_ready", {31'h0, rx_ready0}, 32'h0);
        check("after_rst_tx_ready", {31'h0, tx_ready0}, 32'h1);

        check("exp0_drained", exp0_q.size(), 0);
        check("exp1_drained", exp1_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_modport.md
Name: uart_modport

Overview:
- Slave-side UART endpoint that terminates the serial pins of the UART interface's slave modport.
- Deserializes frames arriving on `tx` (peer → block) and serializes host bytes onto `rx` (block → peer).
- Drives `cts_n` flow control plus `tx_busy`, `rx_ready` and error status pins.
- Sits between the UART pins and a byte-wide host valid/ready interface.

Parameters:
- CLKS_PER_BIT, 1085, clock cycles per bit (125 MHz / 115200); legal range ≥4.
- DATA_BITS, 8, data bits per frame (5–8), LSB first.
- PARITY_EN, 0, 1 = one parity bit after the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even (used only when PARITY_EN=1).

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- tx  input  1  serial line from peer; idle high
- rts_n  input  1  peer ready-to-receive, active low
- rx  output  1  serial line to peer; idle high
- cts_n  output  1  block can accept a byte, active low
- tx_busy  output  1  frame in progress on `tx`
- rx_ready  output  1  frame in progress on `rx`
- frame_error  output  1  last received frame had stop bit = 0
- parity_error  output  1  last received frame had a parity mismatch
- overrun_error  output  1  a frame completed while the holding register was full
- tx_data  input  DATA_BITS  host byte to send
- tx_valid  input  1  host offers tx_data
- tx_ready  output  1  transmitter idle and able to accept a byte
- rx_data  output  DATA_BITS  received byte
- rx_valid  output  1  rx_data holds an unread byte
- rx_ack  input  1  host consumes rx_data

Behaviour:
- Interface: one clock `clk`; `rst` is asynchronous, active-low.
- Reset values: rx=1, cts_n=1, tx_busy=0, rx_ready=0, all error flags=0, tx_ready=0, rx_valid=0, rx_data=0.
- First clock after reset release: cts_n=0, tx_ready=1.
- Reset asserted mid-frame aborts both the receiver and the transmitter immediately and returns them to IDLE.
- All outputs are registered except tx_busy.

Receiver (`tx` → rx_data):
- `tx` passes through a 2-flop synchronizer.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE→START on a synchronized low; a bit-centre counter loads CLKS_PER_BIT/2.
- At the start-bit centre: if the line is high, it was a false start → IDLE with no status change. Otherwise → DATA.
- DATA samples one bit every CLKS_PER_BIT cycles, LSB first.
- PARITY (only if PARITY_EN) samples the parity bit.
- STOP samples the stop bit at its centre, then returns to IDLE immediately (half a bit early, allowing back-to-back frames).
- On stop sample, if rx_valid=0:
  - Load rx_data and set rx_valid the next cycle.
  - frame_error = (stop==0); parity_error = mismatch.
  - Data is delivered even when an error flag is set.
- On stop sample, if rx_valid=1:
  - Drop the new byte; keep the old data and old error flags.
  - Set overrun_error.
- rx_ack while rx_valid=1 clears rx_valid and overrun_error.
- If rx_ack arrives in the same cycle as a new byte loads, the load wins and rx_valid stays 1.
- cts_n = rx_valid, registered.
- tx_busy = (receiver state ≠ IDLE) OR (raw `tx`==0). Combinational, so it is high whenever `tx` is low.

Transmitter (tx_data → `rx`):
- States: IDLE, START, DATA, PARITY, STOP.
- tx_ready=1 only in IDLE.
- Accept on tx_valid & tx_ready & (rts_n==0); the byte is latched.
- If rts_n is high, tx_valid stays pending with no acceptance.
- In the cycle after acceptance: `rx` goes low, rx_ready=1.
- Each bit is held exactly CLKS_PER_BIT cycles: start(0), data LSB first, parity (if enabled), stop(1).
- After the stop bit's last cycle: rx_ready=0 and tx_ready=1.
- Total frame = (1 + DATA_BITS + PARITY_EN + 1) × CLKS_PER_BIT cycles.
- rts_n deasserting mid-frame does not abort the frame.
- Whenever rx_ready=0, rx=1.

Test Plan:
- CLKS_PER_BIT=16, 8N1, rts_n=0, send tx_data=0x55 → rx low at N+1, bits 1,0,1,0,1,0,1,0 each 16 cycles, stop high, rx_ready high 160 cycles, then tx_ready=1.
- Drive 0xA3 serially on tx (8N1) → rx_valid=1 ~152 cycles after the start edge, rx_data=0xA3, frame_error=0, cts_n=1; after rx_ack, rx_valid=0 and cts_n=0.
- Stop bit driven 0 on byte 0x0F → rx_data=0x0F, frame_error=1.
- PARITY_EN=1, even parity, byte 0x07 with parity bit 0 → parity_error=1; with parity bit 1 → parity_error=0.
- Two frames 0x11 then 0x22 with no rx_ack → rx_data=0x11, overrun_error=1; rx_ack clears both rx_valid and overrun_error.
- 4-cycle low glitch on tx → no rx_valid, no error flags.
- Assert rst mid-transmit → rx=1 and rx_ready=0 immediately; transmitter in IDLE.
